alu_muldiv: RTL and testbench

ALU_MULDIV -- requirements
Module: alu_muldiv

---
 rtl/alu_muldiv_if.sv | 28 ++
 rtl/alu_muldiv.sv | 220 ++++++++++++++++++++++
 tb/tb_alu_muldiv.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_muldiv_if.sv
// alu_muldiv_if: request/response bundle for alu_muldiv.
//   master (requester) drives : in_valid, ALU_Control, operand_A, operand_B, out_ready
//   slave  (alu_muldiv) drives: in_ready, out_valid, ALU_result, busy
//   WIDTH : operand/result width in bits (>= 8)

interface alu_muldiv_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [5:0]       ALU_Control;
    logic [WIDTH-1:0] operand_A;
    logic [WIDTH-1:0] operand_B;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] ALU_result;
    logic             busy;

    modport master (
        output in_valid, ALU_Control, operand_A, operand_B, out_ready,
        input  in_ready, out_valid, ALU_result, busy
    );

    modport slave (
        input  in_valid, ALU_Control, operand_A, operand_B, out_ready,
        output in_ready, out_valid, ALU_result, busy
    );
endinterface

// File: rtl/alu_muldiv.sv
// alu_muldiv: ALU with sequential shift-add multiplier and optional restoring divider.
// Valid/ready request in, valid/ready registered result out, one operation in flight.
// Ports:
//   clock : rising-edge clock
//   reset : synchronous, active-high; aborts any operation in flight
//   bus   : alu_muldiv_if.slave (request, operands, result handshake, busy)
// Configuration macro ALU_DIV_EN: when defined, div/divu/rem/remu run on a WIDTH-cycle
// restoring divider; when undefined the divider is absent and those encodings return all ones.

module alu_muldiv #(
    parameter int unsigned WIDTH = 32
) (
    input logic         clock,
    input logic         reset,
    alu_muldiv_if.slave bus
);
    localparam int unsigned CntW   = $clog2(WIDTH);
    localparam int unsigned ShamtW = $clog2(WIDTH);

    localparam logic [5:0] OpAdd   = 6'b000000;
    localparam logic [5:0] OpSub   = 6'b001000;
    localparam logic [5:0] OpSlt   = 6'b000010;
    localparam logic [5:0] OpSltu  = 6'b000011;
    localparam logic [5:0] OpXor   = 6'b000100;
    localparam logic [5:0] OpOr    = 6'b000110;
    localparam logic [5:0] OpAnd   = 6'b000111;
    localparam logic [5:0] OpSll   = 6'b000001;
    localparam logic [5:0] OpSrl   = 6'b000101;
    localparam logic [5:0] OpSra   = 6'b001101;
    localparam logic [5:0] OpMul   = 6'b010000;
    localparam logic [5:0] OpMulh  = 6'b010001;
    localparam logic [5:0] OpMulhu = 6'b010011;
    localparam logic [5:0] OpDiv   = 6'b010100;
    localparam logic [5:0] OpDivu  = 6'b010101;
    localparam logic [5:0] OpRem   = 6'b010110;
    localparam logic [5:0] OpRemu  = 6'b010111;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StMul  = 2'd1,
`ifdef ALU_DIV_EN
        StDiv  = 2'd2,
`endif
        StDone = 2'd3
    } state_e;

    state_e           state_q;
    logic [5:0]       op_q;
    logic [WIDTH-1:0] result_q;
    logic [WIDTH-1:0] hi_q;     // mul: product high half; div: partial remainder
    logic [WIDTH-1:0] lo_q;     // mul: multiplier / product low half; div: dividend -> quotient
    logic [WIDTH-1:0] mcand_q;  // mul: multiplicand magnitude; div: divisor magnitude
    logic [CntW-1:0]  cnt_q;
    logic             neg_q;    // final product / quotient needs negating

    logic              accept;
    logic              is_mul;
    logic              op_signed;
    logic              a_neg;
    logic              b_neg;
    logic [WIDTH-1:0]  mag_a;
    logic [WIDTH-1:0]  mag_b;
    logic [ShamtW-1:0] shamt;
    logic [WIDTH-1:0]  alu_res;
    logic              last_step;

    assign accept    = bus.in_valid && (state_q == StIdle);
    assign is_mul    = bus.ALU_Control inside {OpMul, OpMulh, OpMulhu};
    // mul returns the low half, which is identical for signed and unsigned operands
    assign op_signed = bus.ALU_Control inside {OpMulh, OpDiv, OpRem};
    assign a_neg     = op_signed && bus.operand_A[WIDTH-1];
    assign b_neg     = op_signed && bus.operand_B[WIDTH-1];
    assign mag_a     = a_neg ? -bus.operand_A : bus.operand_A;
    assign mag_b     = b_neg ? -bus.operand_B : bus.operand_B;
    assign shamt     = bus.operand_B[ShamtW-1:0];
    assign last_step = (cnt_q == CntW'(WIDTH - 1));

    // Single-cycle results, computed straight from the request at accept
    always_comb begin
        alu_res = '0;
        case (bus.ALU_Control)
            OpAdd:  alu_res = bus.operand_A + bus.operand_B;
            OpSub:  alu_res = bus.operand_A - bus.operand_B;
            OpSlt:  alu_res = {{(WIDTH-1){1'b0}},
                               $signed(bus.operand_A) < $signed(bus.operand_B)};
            OpSltu: alu_res = {{(WIDTH-1){1'b0}}, bus.operand_A < bus.operand_B};
            OpXor:  alu_res = bus.operand_A ^ bus.operand_B;
            OpOr:   alu_res = bus.operand_A | bus.operand_B;
            OpAnd:  alu_res = bus.operand_A & bus.operand_B;
            OpSll:  alu_res = bus.operand_A << shamt;
            OpSrl:  alu_res = bus.operand_A >> shamt;
            OpSra:  alu_res = $unsigned($signed(bus.operand_A) >>> shamt);
`ifndef ALU_DIV_EN
            OpDiv, OpDivu, OpRem, OpRemu: alu_res = '1;
`endif
            default: alu_res = '0;
        endcase
    end

    // Shift-add step: add multiplicand into the high half, shift the product right by one
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_prod;
    logic [2*WIDTH-1:0] mul_fix;
    logic [WIDTH-1:0]   mul_res;

    always_comb begin
        mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : '0);
        mul_prod = {mul_sum, lo_q[WIDTH-1:1]};
        mul_fix  = neg_q ? -mul_prod : mul_prod;
        mul_res  = (op_q == OpMul) ? mul_fix[WIDTH-1:0] : mul_fix[2*WIDTH-1:WIDTH];
    end

`ifdef ALU_DIV_EN
    logic             negr_q;   // remainder takes the dividend's sign
    logic             dz_q;     // divisor was zero
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_trial;
    logic             div_ge;
    logic [WIDTH-1:0] div_rem;
    logic [WIDTH-1:0] div_quo;
    logic [WIDTH-1:0] quo_fix;
    logic [WIDTH-1:0] rem_fix;
    logic [WIDTH-1:0] div_res;

    // Restoring step: shift next dividend bit into the remainder, keep the trial if >= 0
    always_comb begin
        div_shift = {hi_q, lo_q[WIDTH-1]};
        div_trial = div_shift - {1'b0, mcand_q};
        div_ge    = ~div_trial[WIDTH];
        div_rem   = div_ge ? div_trial[WIDTH-1:0] : div_shift[WIDTH-1:0];
        div_quo   = {lo_q[WIDTH-2:0], div_ge};
        quo_fix   = dz_q ? '1 : (neg_q ? -div_quo : div_quo);
        rem_fix   = negr_q ? -div_rem : div_rem;
        div_res   = (op_q inside {OpDiv, OpDivu}) ? quo_fix : rem_fix;
    end
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= StIdle;
            op_q     <= '0;
            result_q <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            mcand_q  <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
`ifdef ALU_DIV_EN
            negr_q   <= 1'b0;
            dz_q     <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        op_q  <= bus.ALU_Control;
                        cnt_q <= '0;
                        neg_q <= a_neg ^ b_neg;
                        if (is_mul) begin
                            state_q <= StMul;
                            hi_q    <= '0;
                            lo_q    <= mag_b;
                            mcand_q <= mag_a;
                        end
`ifdef ALU_DIV_EN
                        else if (bus.ALU_Control inside {OpDiv, OpDivu, OpRem, OpRemu}) begin
                            state_q <= StDiv;
                            hi_q    <= '0;
                            lo_q    <= mag_a;
                            mcand_q <= mag_b;
                            negr_q  <= a_neg;
                            dz_q    <= (bus.operand_B == '0);
                        end
`endif
                        else begin
                            state_q  <= StDone;
                            result_q <= alu_res;
                        end
                    end
                end
                StMul: begin
                    hi_q  <= mul_prod[2*WIDTH-1:WIDTH];
                    lo_q  <= mul_prod[WIDTH-1:0];
                    cnt_q <= cnt_q + CntW'(1);
                    if (last_step) begin
                        result_q <= mul_res;
                        state_q  <= StDone;
                    end
                end
`ifdef ALU_DIV_EN
                StDiv: begin
                    hi_q  <= div_rem;
                    lo_q  <= div_quo;
                    cnt_q <= cnt_q + CntW'(1);
                    if (last_step) begin
                        result_q <= div_res;
                        state_q  <= StDone;
                    end
                end
`endif
                StDone: begin
                    if (bus.out_ready) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.in_ready   = (state_q == StIdle);
    assign bus.out_valid  = (state_q == StDone);
    assign bus.ALU_result = result_q;
`ifdef ALU_DIV_EN
    assign bus.busy       = (state_q == StMul) || (state_q == StDiv);
`else
    assign bus.busy       = (state_q == StMul);
`endif

endmodule

// File: tb/tb_alu_muldiv.sv
// tb_alu_muldiv: self-checking bench for alu_muldiv (WIDTH = 32).
// Directed corner cases plus randomized operations compared against an arithmetic
// reference model; follows ALU_DIV_EN the same way the design does.

module tb_alu_muldiv;
    localparam int unsigned W = 32;

    localparam logic [5:0] OpAdd   = 6'b000000;
    localparam logic [5:0] OpSub   = 6'b001000;
    localparam logic [5:0] OpSlt   = 6'b000010;
    localparam logic [5:0] OpSltu  = 6'b000011;
    localparam logic [5:0] OpXor   = 6'b000100;
    localparam logic [5:0] OpOr    = 6'b000110;
    localparam logic [5:0] OpAnd   = 6'b000111;
    localparam logic [5:0] OpSll   = 6'b000001;
    localparam logic [5:0] OpSrl   = 6'b000101;
    localparam logic [5:0] OpSra   = 6'b001101;
    localparam logic [5:0] OpMul   = 6'b010000;
    localparam logic [5:0] OpMulh  = 6'b010001;
    localparam logic [5:0] OpMulhu = 6'b010011;
    localparam logic [5:0] OpDiv   = 6'b010100;
    localparam logic [5:0] OpDivu  = 6'b010101;
    localparam logic [5:0] OpRem   = 6'b010110;
    localparam logic [5:0] OpRemu  = 6'b010111;

    logic [5:0]  ops [17] = '{OpAdd, OpSub, OpSlt, OpSltu, OpXor, OpOr, OpAnd, OpSll, OpSrl,
                              OpSra, OpMul, OpMulh, OpMulhu, OpDiv, OpDivu, OpRem, OpRemu};
    logic [31:0] corners [6] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF,
                                 32'h2};

    logic clock = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    alu_muldiv_if #(.WIDTH(W)) bus ();

    alu_muldiv #(.WIDTH(W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference result from plain 64-bit arithmetic
    function automatic logic [31:0] model(input logic [5:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        longint          sa;
        longint          sb;
        longint unsigned ua;
        longint unsigned ub;
        logic [63:0]     p;
        logic [31:0]     r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        r  = 32'd0;
        case (op)
            OpAdd:   r = a + b;
            OpSub:   r = a - b;
            OpSlt:   r = (sa < sb) ? 32'd1 : 32'd0;
            OpSltu:  r = (ua < ub) ? 32'd1 : 32'd0;
            OpXor:   r = a ^ b;
            OpOr:    r = a | b;
            OpAnd:   r = a & b;
            OpSll:   begin p = ua << b[4:0]; r = p[31:0]; end
            OpSrl:   r = a >> b[4:0];
            OpSra:   begin p = sa >>> b[4:0]; r = p[31:0]; end
            OpMul:   begin p = ua * ub; r = p[31:0]; end
            OpMulh:  begin p = sa * sb; r = p[63:32]; end
            OpMulhu: begin p = ua * ub; r = p[63:32]; end
`ifdef ALU_DIV_EN
            OpDiv:   begin p = (b == 0) ? 64'hFFFF_FFFF : sa / sb; r = p[31:0]; end
            OpRem:   begin p = (b == 0) ? ua : sa % sb; r = p[31:0]; end
            OpDivu:  begin p = (b == 0) ? 64'hFFFF_FFFF : ua / ub; r = p[31:0]; end
            OpRemu:  begin p = (b == 0) ? ua : ua % ub; r = p[31:0]; end
`else
            OpDiv, OpDivu, OpRem, OpRemu: r = 32'hFFFF_FFFF;
`endif
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    // Cycles from accept edge to the first cycle with out_valid
    function automatic int exp_lat(input logic [5:0] op);
        if (op inside {OpMul, OpMulh, OpMulhu}) return W + 1;
`ifdef ALU_DIV_EN
        if (op inside {OpDiv, OpDivu, OpRem, OpRemu}) return W + 1;
`endif
        return 1;
    endfunction

    task automatic run_op(input string tag, input logic [5:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int hold);
        int          lat;
        int          busy_cyc;
        int          chg;
        logic [31:0] exp_res;
        logic [31:0] held;
        exp_res = model(op, a, b);
        @(negedge clock);
        check({tag, ".in_ready"}, 64'(bus.in_ready), 64'd1);
        bus.ALU_Control = op;
        bus.operand_A   = a;
        bus.operand_B   = b;
        bus.in_valid    = 1'b1;
        @(posedge clock);
        #1;
        // Scramble inputs after accept; the result must not depend on them
        bus.in_valid    = 1'b0;
        bus.ALU_Control = 6'($urandom);
        bus.operand_A   = $urandom;
        bus.operand_B   = $urandom;
        lat      = 1;
        busy_cyc = 0;
        while (bus.out_valid !== 1'b1 && lat < 200) begin
            if (bus.busy === 1'b1) busy_cyc++;
            @(posedge clock);
            #1;
            lat++;
        end
        check({tag, ".latency"}, 64'(lat), 64'(exp_lat(op)));
        check({tag, ".busy_cycles"}, 64'(busy_cyc), 64'(exp_lat(op) - 1));
        check({tag, ".result"}, 64'(bus.ALU_result), 64'(exp_res));
        held = bus.ALU_result;
        chg  = 0;
        for (int i = 0; i < hold; i++) begin
            @(posedge clock);
            #1;
            if (bus.ALU_result !== held || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0)
                chg++;
        end
        if (hold > 0) check({tag, ".hold_stable"}, 64'(chg), 64'd0);
        // Consume while offering a new request: it must not be taken this cycle
        @(negedge clock);
        bus.out_ready   = 1'b1;
        bus.in_valid    = 1'b1;
        bus.ALU_Control = OpAdd;
        @(posedge clock);
        #1;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        check({tag, ".consumed"}, 64'({bus.out_valid, bus.in_ready, bus.busy}), 64'b010);
    endtask

    initial begin
        logic [5:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int          seen;

        reset           = 1'b1;
        bus.in_valid    = 1'b0;
        bus.out_ready   = 1'b0;
        bus.ALU_Control = '0;
        bus.operand_A   = '0;
        bus.operand_B   = '0;
        repeat (3) @(posedge clock);
        #1;
        check("reset.state", 64'({bus.in_ready, bus.out_valid, bus.busy}), 64'b100);
        check("reset.result", 64'(bus.ALU_result), 64'd0);
        @(negedge clock);
        reset = 1'b0;

        run_op("add_wrap", OpAdd, 32'h7FFF_FFFF, 32'h1, 0);
        run_op("slt_m1_1", OpSlt, 32'hFFFF_FFFF, 32'h1, 0);
        run_op("sltu_m1_1", OpSltu, 32'hFFFF_FFFF, 32'h1, 0);
        run_op("sub_hold10", OpSub, 32'h0000_0003, 32'h0000_0005, 10);
        run_op("sll_amt", OpSll, 32'h8000_0001, 32'hFFFF_FFE5, 0);
        run_op("sra_fill", OpSra, 32'h8000_0000, 32'h0000_001F, 0);
        run_op("bad_op", 6'b111111, 32'h1234_5678, 32'h1, 0);
        run_op("mul_ff", OpMul, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op("mulhu_ff", OpMulhu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op("mulh_ff", OpMulh, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3);
`ifdef ALU_DIV_EN
        run_op("div_m7_2", OpDiv, 32'hFFFF_FFF9, 32'h2, 0);
        run_op("rem_m7_2", OpRem, 32'hFFFF_FFF9, 32'h2, 0);
        run_op("divu_5_0", OpDivu, 32'h5, 32'h0, 0);
        run_op("remu_5_0", OpRemu, 32'h5, 32'h0, 0);
        run_op("div_ovf", OpDiv, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op("rem_ovf", OpRem, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op("rem_m5_0", OpRem, 32'hFFFF_FFFB, 32'h0, 0);
`else
        run_op("div_6_3", OpDiv, 32'h6, 32'h3, 0);
        run_op("remu_6_3", OpRemu, 32'h6, 32'h3, 0);
`endif

        for (int n = 0; n < 60; n++) begin
            op = ($urandom_range(0, 9) == 0) ? 6'($urandom) : ops[$urandom_range(0, 16)];
            a  = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : $urandom;
            b  = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : $urandom;
            run_op($sformatf("rand%0d_op%02h", n, op), op, a, b, $urandom_range(0, 2));
        end

        // Reset 15 cycles into a long operation; nothing may come out afterwards
        @(negedge clock);
`ifdef ALU_DIV_EN
        bus.ALU_Control = OpDivu;
`else
        bus.ALU_Control = OpMulhu;
`endif
        bus.operand_A = 32'hDEAD_BEEF;
        bus.operand_B = 32'h0000_0007;
        bus.in_valid  = 1'b1;
        @(posedge clock);
        #1;
        bus.in_valid = 1'b0;
        repeat (14) @(posedge clock);
        @(negedge clock);
        reset         = 1'b1;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clock);
        #1;
        check("abort.state", 64'({bus.in_ready, bus.out_valid, bus.busy}), 64'b100);
        check("abort.result", 64'(bus.ALU_result), 64'd0);
        @(negedge clock);
        reset         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        seen = 0;
        repeat (40) begin
            @(posedge clock);
            #1;
            if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) seen++;
        end
        check("abort.quiet40", 64'(seen), 64'd0);

        run_op("after_abort", OpXor, 32'hA5A5_A5A5, 32'h0F0F_0F0F, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
